// File: rtl/uart_msg_fifo.sv
// uart_msg_fifo: circular receive FIFO between the UART receiver and the
// message/command decoder. Words can be popped one at a time, or the whole
// stored message can be read as an ordered flattened vector.
//
// Ports:
//   clk_100MHz     system clock, rising edge
//   reset          synchronous active-low reset
//   write_to_fifo  push write_data_in this cycle
//   read_from_fifo pop head word this cycle
//   flush          synchronous clear of contents and flags
//   write_data_in  word to push
//   read_data_out  head word (first-word-fall-through), 0 when empty
//   msg_out        ordered snapshot, oldest word in the most significant slot
//   count          words stored, 0..DEPTH
//   empty          count == 0
//   full           count == DEPTH
//   almost_full    count >= ALMOST_FULL_LEVEL
//   overflow       sticky: a write was dropped because the FIFO was full
module uart_msg_fifo #(
    parameter int unsigned DATA_SIZE         = 8,
    parameter int unsigned ADDR_SPACE_EXP    = 3,
    parameter int unsigned ALMOST_FULL_LEVEL = 6
) (
    input  logic                                          clk_100MHz,
    input  logic                                          reset,
    input  logic                                          write_to_fifo,
    input  logic                                          read_from_fifo,
    input  logic                                          flush,
    input  logic [DATA_SIZE-1:0]                          write_data_in,
    output logic [DATA_SIZE-1:0]                          read_data_out,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]      msg_out,
    output logic [ADDR_SPACE_EXP:0]                       count,
    output logic                                          empty,
    output logic                                          full,
    output logic                                          almost_full,
    output logic                                          overflow
);

    localparam int unsigned DEPTH = 2**ADDR_SPACE_EXP;
    localparam int unsigned AW    = ADDR_SPACE_EXP;
    localparam int unsigned CW    = ADDR_SPACE_EXP + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 read_acc_c;
    logic                 write_acc_c;

    // A read frees a slot, so a write into a full FIFO is accepted alongside it.
    assign read_acc_c  = read_from_fifo && (count != '0);
    assign write_acc_c = write_to_fifo && ((count != CW'(DEPTH)) || read_acc_c);

    // Pointers, occupancy, sticky overflow and storage.
    always_ff @(posedge clk_100MHz) begin
        if (!reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write_acc_c) begin
                mem[wr_ptr] <= write_data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (read_acc_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(write_acc_c) - CW'(read_acc_c);
            if (write_to_fifo && !write_acc_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Flags and data views depend only on registered state; stale memory is
    // masked by count so nothing leaks out after reset or flush.
    assign empty         = (count == '0);
    assign full          = (count == CW'(DEPTH));
    assign almost_full   = (count >= CW'(ALMOST_FULL_LEVEL));
    assign read_data_out = empty ? '0 : mem[rd_ptr];

    // Slot i is taken relative to rd_ptr so message order survives pointer wrap.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_msg
        assign msg_out[(int'(DEPTH)-1-g)*int'(DATA_SIZE) +: int'(DATA_SIZE)] =
            (count > CW'(g)) ? mem[rd_ptr + AW'(g)] : '0;
    end

endmodule

// File: tb/tb_uart_msg_fifo.sv
// Self-checking bench for uart_msg_fifo: a queue-based reference model is
// compared with the DUT every cycle, plus directed literal checks.
module tb_uart_msg_fifo;

    localparam int DW    = 8;
    localparam int AE    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic            clk_100MHz;
    logic            reset;
    logic            write_to_fifo;
    logic            read_from_fifo;
    logic            flush;
    logic [DW-1:0]   write_data_in;
    logic [DW-1:0]   read_data_out;
    logic [DW*DEPTH-1:0] msg_out;
    logic [AE:0]     count;
    logic            empty;
    logic            full;
    logic            almost_full;
    logic            overflow;

    int checks   = 0;
    int failures = 0;
    bit run      = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 0;

    uart_msg_fifo #(.DATA_SIZE(DW), .ADDR_SPACE_EXP(AE), .ALMOST_FULL_LEVEL(AFL)) dut (
        .clk_100MHz     (clk_100MHz),
        .reset          (reset),
        .write_to_fifo  (write_to_fifo),
        .read_from_fifo (read_from_fifo),
        .flush          (flush),
        .write_data_in  (write_data_in),
        .read_data_out  (read_data_out),
        .msg_out        (msg_out),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated from the rules on each edge.
    always @(posedge clk_100MHz) begin
        bit rd, wr;
        if (!reset || flush) begin
            q.delete();
            m_ovf = 0;
        end else begin
            rd = read_from_fifo && (q.size() > 0);
            wr = write_to_fifo && ((q.size() < DEPTH) || rd);
            if (write_to_fifo && !wr) m_ovf = 1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(write_data_in);
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk_100MHz) begin
        logic [63:0] em;
        logic [DW-1:0] eh;
        if (run) begin
            em = '0;
            for (int i = 0; i < q.size(); i++) em[(DEPTH-1-i)*DW +: DW] = q[i];
            eh = (q.size() > 0) ? q[0] : '0;
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_empty", 64'(empty), 64'(q.size() == 0));
            chk("m_full", 64'(full), 64'(q.size() == DEPTH));
            chk("m_almost_full", 64'(almost_full), 64'(q.size() >= AFL));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
            chk("m_read_data", 64'(read_data_out), 64'(eh));
            chk("m_msg", 64'(msg_out), em);
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge that used them.
    task automatic step(input bit rst_n, input bit fl, input bit w, input bit r, input logic [7:0] d);
        reset          = rst_n;
        flush          = fl;
        write_to_fifo  = w;
        read_from_fifo = r;
        write_data_in  = d;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic push(input logic [7:0] d); step(1, 0, 1, 0, d); endtask
    task automatic pop();                     step(1, 0, 0, 1, 8'h00); endtask
    task automatic idle();                    step(1, 0, 0, 0, 8'h00); endtask
    task automatic do_flush();                step(1, 1, 0, 0, 8'h00); endtask

    initial begin
        reset = 0; flush = 0; write_to_fifo = 0; read_from_fifo = 0; write_data_in = '0;

        // 1: reset state
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        run = 1;
        idle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_rdo", 64'(read_data_out), 64'd0);
        chk("rst_msg", 64'(msg_out), 64'd0);

        // 2: push three, pop one
        push(8'h41);
        chk("fwft_rdo", 64'(read_data_out), 64'h41);
        push(8'h42);
        push(8'h43);
        chk("three_count", 64'(count), 64'd3);
        pop();
        chk("pop_rdo", 64'(read_data_out), 64'h42);
        chk("pop_count", 64'(count), 64'd2);
        chk("pop_msg", 64'(msg_out), 64'h4243_0000_0000_0000);

        // 3: fill, thresholds, overflow
        do_flush();
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h30 + i));
            if (i == 4) chk("af_at5", 64'(almost_full), 64'd0);
            if (i == 5) chk("af_at6", 64'(almost_full), 64'd1);
            if (i == 6) chk("full_at7", 64'(full), 64'd0);
        end
        chk("full_at8", 64'(full), 64'd1);
        push(8'hFF);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_msg", 64'(msg_out), 64'h3031_3233_3435_3637);

        // 4: wrap
        do_flush();
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 5; i++) pop();
        push(8'h50); push(8'h51); push(8'h52);
        chk("wrap_count", 64'(count), 64'd6);
        chk("wrap_msg", 64'(msg_out), 64'h3536_3750_5152_0000);
        begin
            logic [7:0] order [6];
            order = '{8'h35, 8'h36, 8'h37, 8'h50, 8'h51, 8'h52};
            for (int i = 0; i < 6; i++) begin
                chk("wrap_pop_order", 64'(read_data_out), 64'(order[i]));
                pop();
            end
        end
        chk("wrap_empty", 64'(empty), 64'd1);

        // 5: simultaneous read/write at full and at empty
        do_flush();
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        step(1, 0, 1, 1, 8'h60);
        chk("rw_full_count", 64'(count), 64'd8);
        chk("rw_full_ovf", 64'(overflow), 64'd0);
        chk("rw_full_head", 64'(read_data_out), 64'h11);
        chk("rw_full_msg", 64'(msg_out), 64'h1112_1314_1516_1760);
        do_flush();
        step(1, 0, 1, 1, 8'h61);
        chk("rw_empty_count", 64'(count), 64'd1);
        chk("rw_empty_rdo", 64'(read_data_out), 64'h61);

        // 6: flush and reset take priority over a concurrent write
        do_flush();
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 4; i++) pop();
        chk("pre_flush_count", 64'(count), 64'd4);
        chk("pre_flush_ovf", 64'(overflow), 64'd1);
        step(1, 1, 1, 0, 8'h70);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ovf", 64'(overflow), 64'd0);
        push(8'h71);
        chk("flush_not_stored", 64'(read_data_out), 64'h71);
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        step(0, 0, 1, 1, 8'h70);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_ovf", 64'(overflow), 64'd0);
        chk("rst_mid_msg", 64'(msg_out), 64'd0);
        push(8'h72);
        chk("rst_not_stored", 64'(read_data_out), 64'h72);

        // Random traffic, write-heavy then read-heavy phases
        for (int c = 0; c < 3000; c++) begin
            int wp;
            wp = ((c / 300) % 2 == 0) ? 75 : 35;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < 50),
                 8'($urandom));
        end

        idle();
        run = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_msg_fifo.md
Name: uart_msg_fifo

Overview:
Parametrised circular FIFO for the UART receive path. It replaces the fill-then-dump buffer with independent read and write pointers. It supports word-by-word pops, simultaneous read/write, occupancy count, almost-full and sticky overflow flags, and a synchronous flush. It sits between the UART receiver and the message/command decoder, which can either pop single words or take the whole message as an ordered flattened vector.

Parameters:
DATA_SIZE, 8, bits per data word (>=1)
ADDR_SPACE_EXP, 3, address bits; DEPTH = 2**ADDR_SPACE_EXP words (>=1)
ALMOST_FULL_LEVEL, 6, count at or above which almost_full asserts (1..DEPTH)

Ports:
clk_100MHz  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk_100MHz
write_to_fifo  input  1  push write_data_in this cycle
read_from_fifo  input  1  pop head word this cycle
flush  input  1  synchronous clear of contents and flags
write_data_in  input  DATA_SIZE  word to push
read_data_out  output  DATA_SIZE  head word, first-word-fall-through
msg_out  output  DATA_SIZE*DEPTH  ordered snapshot, oldest word in MS slot
count  output  ADDR_SPACE_EXP+1  words currently stored, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=ALMOST_FULL_LEVEL
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at an edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Memory contents are not cleared, but all outputs are masked: empty=1, full=0, almost_full=0, read_data_out=0, msg_out=0.
- Priority per edge: reset > flush > read/write.
- flush=1: same effect as reset on pointers, count and overflow. Any read or write in the same cycle is ignored.
- Write accepted when write_to_fifo=1 and (count<DEPTH, or read accepted in the same cycle). An accepted write stores mem[wr_ptr]<=write_data_in and increments wr_ptr modulo DEPTH (natural wrap).
- Read accepted when read_from_fifo=1 and count>0. It increments rd_ptr modulo DEPTH.
- count next = count + write_acc - read_acc. Both accepted: count unchanged, pointers both advance.
- Full with write+read in the same cycle: both accepted; the new word lands in the slot just freed; overflow is not set.
- Empty with write+read in the same cycle: write accepted, read ignored, count becomes 1.
- Write while full without a read: word dropped, pointers and count unchanged, overflow<=1. overflow holds until reset or flush.
- Read while empty: no effect; it does not set any flag.
- Flags are registered-equivalent, derived from registered count, and valid the cycle after the causing edge. There are no combinational paths from inputs to outputs.
- read_data_out = mem[rd_ptr] when count>0, else 0. It updates the cycle after a push into an empty FIFO (zero extra latency beyond the write edge).
- msg_out: slot i (i=0 is the most significant DATA_SIZE bits) = mem[(rd_ptr+i) mod DEPTH] if i<count, else 0. This keeps message order correct across pointer wrap.
- Pointer widths are ADDR_SPACE_EXP bits. count is one bit wider so that full is distinguished from empty.
- All state is in one clocked process. Memory is written only on an accepted write.

Test Plan:
1. Reset held low 2 cycles, then released -> count=0, empty=1, full=0, almost_full=0, overflow=0, read_data_out=0, msg_out=0.
2. Push 0x41,0x42,0x43, then pop once -> read_data_out=0x41 after first push; count=3 before pop; after pop read_data_out=0x42, count=2, msg_out MS bytes 0x42,0x43, rest 0.
3. Push 8 words 0x30..0x37 -> almost_full=1 at count 6; full=1 at count 8. A 9th push of 0xFF -> dropped, overflow=1, count=8, msg_out=0x3031323334353637.
4. Wrap: push 8 words, pop 5, push 0x50,0x51,0x52 -> count=6; msg_out=0x353637505152 followed by 0x0000. Pop order is 0x35,0x36,0x37,0x50,0x51,0x52.
5. Simultaneous: with full, assert write 0x60 and read together -> count stays 8, overflow stays 0, head advances. With empty, write 0x61 and read together -> count=1, read_data_out=0x61.
6. With count=4 and overflow=1, assert flush together with a write of 0x70 -> next cycle count=0, empty=1, overflow=0, 0x70 not stored. Reset asserted mid-stream behaves identically.
